bs_gnrtr_n_rbtr: RTL and testbench

Bus generator and arbiter that emulates a shared packet bus between `drvrs` devices. Each device exposes a first-word-fall-through transmit FIFO (`pndng`/`D_pop`/`pop`) and a receive FIFO (`push`/`D_push`). The block picks pending senders round-robin, pops one packet, decodes the destination ID in the packet's top byte, and pushes the packet into the destination receive FIFO(s). It sits between the device-side FIFO models and is the DUT of the bus-driver verification environment.

---
 rtl/bs_gnrtr_n_rbtr.sv | 115 +++++++++++
 tb/tb_bs_gnrtr_n_rbtr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared packet bus emulator: per-bus round-robin arbiter that pops one packet
// from a device TX FIFO and pushes it to the addressed RX FIFO(s). Optional BS_BROADCAST_EN.
module bs_gnrtr_n_rbtr #(
    parameter int unsigned bits      = 1,
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [bits-1:0][drvrs-1:0]                pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [bits-1:0][drvrs-1:0]                pop,
    output logic [bits-1:0][drvrs-1:0]                push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push
);

    localparam int unsigned DW = drvrs;
    localparam int unsigned IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Release of reset is delayed one edge so arbitration starts on the second edge.
    logic rst_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_q <= 1'b1;
        else       rst_q <= 1'b0;
    end

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t              state;
        logic [IW-1:0]       last;
        logic [IW-1:0]       src;
        logic [pckg_sz-1:0]  pkt;
        logic [DW-1:0]       pop_q;
        logic [DW-1:0]       push_q;
        logic [pckg_sz-1:0]  dpush_q;
        logic                gnt_vld;
        logic [IW-1:0]       gnt_idx;
        logic [IW-1:0]       sel;
        logic [7:0]          id;
        logic [DW-1:0]       mask;

        // Round-robin scan from last+1; scanning backwards lets the nearest requester win.
        always_comb begin
            gnt_vld = 1'b0;
            gnt_idx = '0;
            sel     = '0;
            for (int i = DW; i >= 1; i--) begin
                sel = IW'((32'(last) + 32'(i)) % DW);
                if (pndng[b][sel]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = sel;
                end
            end
        end

        assign id = pkt[pckg_sz-1 -: 8];

        // Destination decode; out-of-range IDs produce an empty mask and the packet is dropped.
        always_comb begin
            mask = '0;
            if (32'(id) < DW) begin
                mask = DW'(1) << id;
            end
`ifdef BS_BROADCAST_EN
            else if (id == broadcast) begin
                mask = ~(DW'(1) << src);
            end
`endif
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= IDLE;
                last    <= IW'(drvrs - 1);
                src     <= '0;
                pkt     <= '0;
                pop_q   <= '0;
                push_q  <= '0;
                dpush_q <= '0;
            end else begin
                pop_q  <= '0;
                push_q <= '0;
                case (state)
                    IDLE: begin
                        if (!rst_q && gnt_vld) begin
                            src   <= gnt_idx;
                            pkt   <= D_pop[b][gnt_idx];
                            pop_q <= DW'(1) << gnt_idx;
                            state <= DELIVER;
                        end
                    end
                    DELIVER: begin
                        dpush_q <= pkt;
                        push_q  <= mask;
                        last    <= src;
                        state   <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end

        assign pop[b]    = pop_q;
        assign push[b]   = push_q;
        assign D_push[b] = {DW{dpush_q}};
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Scoreboard bench for bs_gnrtr_n_rbtr (one bus, eight devices, 16-bit packets).
module tb_bs_gnrtr_n_rbtr;

    localparam int unsigned N = 8;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [N-1:0] mask;
        logic [W-1:0] data;
    } push_t;

    logic                      clk   = 1'b0;
    logic                      reset = 1'b1;
    logic [0:0][N-1:0]         pndng = '0;
    logic [0:0][N-1:0][W-1:0]  D_pop = '0;
    logic [0:0][N-1:0]         pop;
    logic [0:0][N-1:0]         push;
    logic [0:0][N-1:0][W-1:0]  D_push;

    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    int    last_pop_cyc = -10;
    int    pop_cyc[$];
    int    exp_pop[$];
    push_t exp_push[$];
    logic [W-1:0] txq[N][$];
    push_t e;
    int    idx;

    bs_gnrtr_n_rbtr #(
        .bits(1), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmit FIFO models: dequeue on pop, then refresh pndng/D_pop well before the next edge.
    always @(negedge clk) begin
        for (int d = 0; d < N; d++)
            if (pop[0][d] && txq[d].size() > 0) void'(txq[d].pop_front());
        #1;
        for (int d = 0; d < N; d++) begin
            pndng[0][d] = (txq[d].size() > 0);
            D_pop[0][d] = (txq[d].size() > 0) ? txq[d][0] : '0;
        end
    end

    // Scoreboard: compare every pop and push strobe against the expectation queues.
    always @(negedge clk) begin
        if (pop[0] !== '0) begin
            pop_cyc.push_back(cyc);
            last_pop_cyc = cyc;
            checks++;
            if (exp_pop.size() == 0) begin
                $display("FAIL pop_unexpected: pop=%b, expected no grant", pop[0]);
            end else begin
                idx = exp_pop.pop_front();
                if (pop[0] !== (N'(1) << idx))
                    $display("FAIL pop_grant: pop=%b, expected device %0d", pop[0], idx);
                else passes++;
            end
        end
        if (push[0] !== '0) begin
            checks++;
            if (exp_push.size() == 0) begin
                $display("FAIL push_unexpected: push=%b D_push=%h, expected none", push[0], D_push[0][0]);
            end else begin
                e = exp_push.pop_front();
                if ({push[0], D_push[0]} !== {e.mask, {N{e.data}}})
                    $display("FAIL push_data: push=%b D_push=%h, expected push=%b data=%h",
                             push[0], D_push[0], e.mask, e.data);
                else passes++;
            end
            checks++;
            if (cyc !== last_pop_cyc + 1)
                $display("FAIL push_latency: push at cycle %0d, expected %0d", cyc, last_pop_cyc + 1);
            else passes++;
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        for (int d = 0; d < N; d++) txq[d].delete();
        exp_pop.delete();
        exp_push.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((exp_pop.size() != 0 || exp_push.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        bit toggled = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pop[0] !== '0) $display("FAIL reset_pop: pop=%b, expected 0", pop[0]); else passes++;
        checks++; if (push[0] !== '0) $display("FAIL reset_push: push=%b, expected 0", push[0]); else passes++;
        checks++; if (D_push[0] !== '0) $display("FAIL reset_dpush: D_push=%h, expected 0", D_push[0]); else passes++;
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pop[0] !== '0 || push[0] !== '0) toggled = 1'b1;
        end
        checks++; if (toggled !== 1'b0) $display("FAIL idle_quiet: toggled=%b, expected 0", toggled); else passes++;
        checks++; if (D_push[0] !== '0) $display("FAIL idle_dpush: D_push=%h, expected 0", D_push[0]); else passes++;
    endtask

    task automatic test_single();
        txq[2].push_back(16'h05AB);
        exp_pop.push_back(2);
        exp_push.push_back('{mask: 8'b0010_0000, data: 16'h05AB});
        wait_idle(20);
        checks++;
        if (exp_pop.size() + exp_push.size() !== 0)
            $display("FAIL single_drain: %0d expectations left, expected 0", exp_pop.size() + exp_push.size());
        else passes++;
        checks++;
        if (D_push[0][6] !== 16'h05AB) $display("FAIL single_hold: D_push=%h, expected 05ab", D_push[0][6]);
        else passes++;
    endtask

    task automatic test_round_robin();
        int devs[3] = '{0, 3, 7};
        logic [W-1:0] w;
        apply_reset();
        pop_cyc.delete();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                w = W'(32'h0100 + 32'(devs[k]) * 16 + 32'(r));
                txq[devs[k]].push_back(w);
                exp_pop.push_back(devs[k]);
                exp_push.push_back('{mask: 8'b0000_0010, data: w});
            end
        end
        wait_idle(60);
        checks++;
        if (exp_pop.size() + exp_push.size() !== 0)
            $display("FAIL rr_drain: %0d expectations left, expected 0", exp_pop.size() + exp_push.size());
        else passes++;
        checks++;
        if (pop_cyc.size() !== 6) $display("FAIL rr_count: %0d pops, expected 6", pop_cyc.size());
        else passes++;
        for (int i = 1; i < pop_cyc.size(); i++) begin
            checks++;
            if (pop_cyc[i] - pop_cyc[i-1] !== 3)
                $display("FAIL rr_gap: gap %0d cycles, expected 3", pop_cyc[i] - pop_cyc[i-1]);
            else passes++;
        end
    endtask

    task automatic test_broadcast();
        txq[4].push_back(16'hFF12);
        exp_pop.push_back(4);
`ifdef BS_BROADCAST_EN
        exp_push.push_back('{mask: 8'b1110_1111, data: 16'hFF12});
`endif
        wait_idle(20);
        checks++;
        if (exp_pop.size() + exp_push.size() !== 0)
            $display("FAIL bcast_drain: %0d expectations left, expected 0", exp_pop.size() + exp_push.size());
        else passes++;
        checks++;
        if (D_push[0][0] !== 16'hFF12) $display("FAIL bcast_dpush: D_push=%h, expected ff12", D_push[0][0]);
        else passes++;
    endtask

    task automatic test_bad_dest();
        txq[1].push_back(16'h0933);
        exp_pop.push_back(1);
        wait_idle(20);
        checks++;
        if (exp_pop.size() !== 0) $display("FAIL bad_drain: %0d pops left, expected 0", exp_pop.size());
        else passes++;
        txq[6].push_back(16'h0377);
        exp_pop.push_back(6);
        exp_push.push_back('{mask: 8'b0000_1000, data: 16'h0377});
        wait_idle(20);
        checks++;
        if (exp_pop.size() + exp_push.size() !== 0)
            $display("FAIL bad_after_drain: %0d expectations left, expected 0", exp_pop.size() + exp_push.size());
        else passes++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        txq[5].push_back(16'h0244);
        exp_pop.push_back(5);
        while (pop[0] === '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pop[0] !== 8'b0010_0000) $display("FAIL mid_pop: pop=%b, expected 00100000", pop[0]);
        else passes++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({pop[0], push[0]} !== '0) $display("FAIL mid_clear: pop=%b push=%b, expected 0", pop[0], push[0]);
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (push[0] !== '0) $display("FAIL mid_push: push=%b, expected 0", push[0]);
        else passes++;
        reset = 1'b0;
        txq[7].push_back(16'h0011);
        txq[2].push_back(16'h0022);
        exp_pop.push_back(2);
        exp_pop.push_back(7);
        exp_push.push_back('{mask: 8'b0000_0001, data: 16'h0022});
        exp_push.push_back('{mask: 8'b0000_0001, data: 16'h0011});
        wait_idle(30);
        checks++;
        if (exp_pop.size() + exp_push.size() !== 0)
            $display("FAIL mid_drain: %0d expectations left, expected 0", exp_pop.size() + exp_push.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_broadcast();
        test_bad_dest();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
